// File: rtl/ser_frame_arbiter.sv
// ser_frame_arbiter: two-source frame arbiter feeding a byte serializer.
// Ports: clk/rst (sync, active-high); en gates new frames;
//   src_valid/src_data0/src_data1/src_last in, src_ready out per source;
//   ser_dr request in; ser_data/ser_oe out; grant/busy/underrun status.
`timescale 1ns/1ps
module ser_frame_arbiter #(
   parameter logic [7:0] IDLE_BYTE = 8'h00,
   parameter logic [7:0] SOF_BYTE  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] src_valid,
   input  logic [7:0] src_data0,
   input  logic [7:0] src_data1,
   input  logic [1:0] src_last,
   output logic [1:0] src_ready,
   input  logic       ser_dr,
   output logic [7:0] ser_data,
   output logic       ser_oe,
   output logic       grant,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHID,
      ST_PAYLOAD
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       oe_q;
   logic       grant_q, grant_d;
   logic       und_q, und_d;

   logic       g_valid;
   logic       g_last;
   logic [7:0] g_data;
   logic       sel;

   // Only the granted source is ever looked at during a frame.
   assign g_valid = src_valid[grant_q];
   assign g_last  = src_last[grant_q];
   assign g_data  = grant_q ? src_data1 : src_data0;

   // Tie goes to the source that did not own the last frame.
   assign sel = (&src_valid) ? ~grant_q : src_valid[1];

   assign busy = (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      grant_d   = grant_q;
      und_d     = 1'b0;
      src_ready = 2'b00;
      if (ser_dr) begin
         unique case (state_q)
            ST_IDLE: begin
               if (oe_q && en && (|src_valid)) begin
                  grant_d = sel;
                  data_d  = SOF_BYTE;
                  state_d = ST_CHID;
               end else begin
                  data_d  = IDLE_BYTE;
               end
            end
            ST_CHID: begin
               data_d  = {7'b0, grant_q};
               state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (g_valid) begin
                  data_d             = g_data;
                  src_ready[grant_q] = ~rst;
                  if (g_last) state_d = ST_IDLE;
               end else begin
                  data_d = IDLE_BYTE;
                  und_d  = 1'b1;
               end
            end
            default: begin
               data_d  = IDLE_BYTE;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= IDLE_BYTE;
         oe_q    <= 1'b0;
         grant_q <= 1'b1;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         oe_q    <= en | busy;
         grant_q <= grant_d;
         und_q   <= und_d;
      end
   end

   assign ser_data = data_q;
   assign ser_oe   = oe_q;
   assign grant    = grant_q;
   assign underrun = und_q;

endmodule

// File: doc/ser_frame_arbiter.md
SER_FRAME_ARBITER -- requirements
Module: ser_frame_arbiter

Interface
REQ-001 Parameter IDLE_BYTE, default 8'h00, byte presented to the serializer when no frame is active or on payload underrun.
REQ-002 Parameter SOF_BYTE, default 8'hA5, start-of-frame byte opening every frame.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 en  in  1  frame-start enable; frames start only while high.
REQ-006 src_valid  in  2  per-source byte valid, index = source id.
REQ-007 src_data0 / src_data1  in  8 each  source payload byte, held stable while valid.
REQ-008 src_last  in  2  per-source marker: current byte ends the frame.
REQ-009 src_ready  out  2  per-source accept strobe; a byte transfers when valid and ready are both high.
REQ-010 ser_dr  in  1  serializer data request, one-cycle pulse; serializer takes ser_data on that edge.
REQ-011 ser_data  out  8  registered byte presented to the serializer.
REQ-012 ser_oe  out  1  registered serializer output enable.
REQ-013 grant  out  1  registered id of the source owning the current or last frame.
REQ-014 busy  out  1  high while state is not ST_IDLE.
REQ-015 underrun  out  1  one-cycle pulse on payload underrun.

Function
REQ-016 FSM states ST_IDLE, ST_CHID, ST_PAYLOAD; state and ser_data change only in cycles with ser_dr=1, except ser_oe.
REQ-017 ser_oe shall be updated every cycle to en | busy, one-cycle latency.
REQ-018 ST_IDLE with ser_dr=1, ser_oe=1, en=1 and any src_valid: select source, load SOF_BYTE into ser_data, go to ST_CHID; otherwise load IDLE_BYTE and stay.
REQ-019 Selection: one source valid -> that source; both valid -> ~grant (round robin); grant updates on the SOF load cycle.
REQ-020 ST_CHID with ser_dr=1: load {7'b0, grant}, go to ST_PAYLOAD.
REQ-021 ST_PAYLOAD with ser_dr=1 and src_valid[grant]=1: load that source's data, src_ready[grant]=1 same cycle; if src_last[grant]=1 go to ST_IDLE, else stay.
REQ-022 ST_PAYLOAD with ser_dr=1 and src_valid[grant]=0: load IDLE_BYTE, pulse underrun, stay in ST_PAYLOAD, no src_ready.
REQ-023 src_ready shall be combinational, equal to ser_dr & (state==ST_PAYLOAD) & src_valid[grant] on bit grant, 0 on the other bit; never two bits high.
REQ-024 Non-granted source is never read during a frame regardless of its valid/last.
REQ-025 en deassertion mid-frame shall not abort; the frame completes, then no new frame starts.
REQ-026 ser_dr while ser_oe=0 in ST_IDLE: load IDLE_BYTE, no frame start.
REQ-027 Frame length unbounded; single-byte payload (last on first byte) legal: SOF, CHID, byte, then ST_IDLE.
REQ-028 Next frame may start on the ser_dr immediately following the last-byte load (no forced idle byte).

Reset
REQ-029 While rst=1: state ST_IDLE, ser_data=IDLE_BYTE, ser_oe=0, grant=1 (so source 0 wins first tie), underrun=0, src_ready=0.
REQ-030 rst has priority over ser_dr, en and src handshakes in the same cycle; reset mid-frame discards the frame with no src_ready.

Verification
REQ-031 Reset, en=1, no valid, ten ser_dr pulses -> ser_data stays 8'h00, busy=0, ser_oe=1 one cycle after en.
REQ-032 Source 0 sends 8'h11, 8'h22(last) -> ser_data sequence A5, 00, 11, 22, then 00; src_ready[0] pulses twice, grant=0.
REQ-033 Both sources valid continuously, 1-byte frames each -> ids alternate 00, 01, 00, 01 starting with source 0.
REQ-034 Source 1 drops valid for one ser_dr mid-payload -> 8'h00 byte inserted, underrun pulses once, frame resumes with next byte.
REQ-035 en cleared during a 4-byte payload -> all 4 bytes sent, then IDLE_BYTE only, ser_oe falls one cycle after busy falls.
REQ-036 rst asserted in ST_PAYLOAD coincident with ser_dr -> next cycle ser_data=00, state ST_IDLE, src_ready=0, ser_oe=0.
